// File: rtl/wb_pkg.sv
// Shared types for the writeback stage and its store buffer.
package wb_pkg;

  // Store-entry fields are sized for the widest supported bus. The top zero-extends
  // into them and truncates back out.
  localparam int unsigned MaxBusWidth = 64;

  typedef enum logic [1:0] {
    MemByte   = 2'd0,
    MemHalf   = 2'd1,
    MemWord   = 2'd2,
    MemDouble = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic [MaxBusWidth-1:0] addr;
    logic [MaxBusWidth-1:0] data;
    mem_size_e              size;
  } stbuf_entry_t;

endpackage

// File: rtl/stbuf_fifo.sv
// Store-buffer FIFO: power-of-two depth, wrapping pointers, registered occupancy count.
// A write while full is dropped. The caller must stall instead, because there is no
// full-bypass path.
module stbuf_fifo #(
  parameter int unsigned EntryW = 8,
  parameter int unsigned Depth  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [EntryW-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  output logic [EntryW-1:0]        rd_data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  logic [EntryW-1:0] mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_wr, do_rd;

  assign full_o    = (count_q == FullCount);
  assign empty_o   = (count_q == '0);
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Next-state pointers and count. Power-of-two depth makes the pointer wrap free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state. Reset discards any buffered entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage. It is not reset because the count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/writeback_stbuf.sv
// Writeback stage with a store buffer.
// Optional feature: define WB_LOAD_EXT_EN to size-extract and sign/zero-extend load
// data. Without it, load data passes through raw.
module writeback_stbuf
  import wb_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned STBUF_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          inValid,
  input  logic                          inMemOrReg,
  input  logic [BUS_DATA_WIDTH-1:0]     inReadData,
  input  logic [BUS_DATA_WIDTH-1:0]     inResult,
  input  logic [BUS_DATA_WIDTH-1:0]     inDataReg2,
  input  logic [4:0]                    inDestRegister,
  input  logic                          inRegWrite,
  input  logic                          inMemWrite,
  input  logic [1:0]                    inMemSize,
  input  logic                          inLoadUnsigned,
  input  logic                          inStoreReady,
  output logic                          outStall,
  output logic [BUS_DATA_WIDTH-1:0]     outRegData,
  output logic [4:0]                    outDestRegister,
  output logic                          outRegWrite,
  output logic                          outStoreValid,
  output logic [BUS_DATA_WIDTH-1:0]     outStoreAddr,
  output logic [BUS_DATA_WIDTH-1:0]     outStoreData,
  output logic [1:0]                    outStoreSize,
  output logic [$clog2(STBUF_DEPTH):0]  outStbufCount,
  output logic                          outStbufEmpty
);

  localparam int unsigned EntryW = $bits(stbuf_entry_t);

  logic [BUS_DATA_WIDTH-1:0] load_val, wr_data;
  logic [BUS_DATA_WIDTH-1:0] reg_data_q;
  logic [4:0]                dest_q;
  logic                      reg_write_q;
  logic                      accept, enq, deq, stbuf_full, stbuf_empty;
  stbuf_entry_t              enq_entry, head_entry;

`ifdef WB_LOAD_EXT_EN
  int unsigned load_bits;
  logic        load_sign;

  // Keep the low 1/2/4/8 bytes and fill the rest with the sign bit, or zero if unsigned.
  always_comb begin
    load_bits = 32'd8 << inMemSize;
    if (load_bits > BUS_DATA_WIDTH) load_bits = BUS_DATA_WIDTH;
    load_sign = ~inLoadUnsigned & inReadData[load_bits-1];
    load_val  = '0;
    for (int unsigned i = 0; i < BUS_DATA_WIDTH; i++) begin
      load_val[i] = (i < load_bits) ? inReadData[i] : load_sign;
    end
  end
`else
  logic unused_load_unsigned;
  assign unused_load_unsigned = inLoadUnsigned;
  assign load_val             = inReadData;
`endif

  assign wr_data  = inMemOrReg ? inResult : load_val;
  // A full buffer stalls the store even if the head drains this cycle.
  assign outStall = inValid & inMemWrite & stbuf_full;
  assign accept   = inValid & ~outStall;
  assign enq      = accept & inMemWrite;
  assign deq      = ~stbuf_empty & inStoreReady;

  // Build the buffer entry. Fields are zero-extended to the package width.
  always_comb begin
    enq_entry      = '0;
    enq_entry.addr = MaxBusWidth'(inResult);
    enq_entry.data = MaxBusWidth'(inDataReg2);
    enq_entry.size = mem_size_e'(inMemSize);
  end

  stbuf_fifo #(
    .EntryW (EntryW),
    .Depth  (STBUF_DEPTH)
  ) u_stbuf_fifo (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .wr_en_i   (enq),
    .wr_data_i (enq_entry),
    .rd_en_i   (deq),
    .rd_data_o (head_entry),
    .count_o   (outStbufCount),
    .full_o    (stbuf_full),
    .empty_o   (stbuf_empty)
  );

  // Register the writeback result. Data and destination hold when nothing is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_data_q  <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
    end else begin
      reg_write_q <= accept & inRegWrite & (inDestRegister != 5'd0);
      if (accept) begin
        reg_data_q <= wr_data;
        dest_q     <= inDestRegister;
      end
    end
  end

  assign outRegData      = reg_data_q;
  assign outDestRegister = dest_q;
  assign outRegWrite     = reg_write_q;
  assign outStoreValid   = ~stbuf_empty;
  assign outStbufEmpty   = stbuf_empty;
  assign outStoreAddr    = head_entry.addr[BUS_DATA_WIDTH-1:0];
  assign outStoreData    = head_entry.data[BUS_DATA_WIDTH-1:0];
  assign outStoreSize    = head_entry.size;

endmodule

// File: tb/tb_writeback_stbuf.sv
// Directed bench for writeback_stbuf. Inputs change and outputs are sampled on negedge.
module tb_writeback_stbuf;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inValid, inMemOrReg, inRegWrite, inMemWrite, inLoadUnsigned, inStoreReady;
  logic [63:0] inReadData, inResult, inDataReg2;
  logic [4:0]  inDestRegister;
  logic [1:0]  inMemSize;
  logic        outStall, outRegWrite, outStoreValid, outStbufEmpty;
  logic [63:0] outRegData, outStoreAddr, outStoreData;
  logic [4:0]  outDestRegister;
  logic [1:0]  outStoreSize;
  logic [2:0]  outStbufCount;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  writeback_stbuf #(
    .BUS_DATA_WIDTH (64),
    .STBUF_DEPTH    (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .inValid         (inValid),
    .inMemOrReg      (inMemOrReg),
    .inReadData      (inReadData),
    .inResult        (inResult),
    .inDataReg2      (inDataReg2),
    .inDestRegister  (inDestRegister),
    .inRegWrite      (inRegWrite),
    .inMemWrite      (inMemWrite),
    .inMemSize       (inMemSize),
    .inLoadUnsigned  (inLoadUnsigned),
    .inStoreReady    (inStoreReady),
    .outStall        (outStall),
    .outRegData      (outRegData),
    .outDestRegister (outDestRegister),
    .outRegWrite     (outRegWrite),
    .outStoreValid   (outStoreValid),
    .outStoreAddr    (outStoreAddr),
    .outStoreData    (outStoreData),
    .outStoreSize    (outStoreSize),
    .outStbufCount   (outStbufCount),
    .outStbufEmpty   (outStbufEmpty)
  );

  task automatic idle();
    inValid = 0; inMemOrReg = 0; inRegWrite = 0; inMemWrite = 0; inLoadUnsigned = 0;
    inReadData = 0; inResult = 0; inDataReg2 = 0; inDestRegister = 0; inMemSize = 0;
  endtask

  task automatic do_store(input logic [63:0] addr, input logic [63:0] data,
                          input logic [1:0] size);
    inValid = 1; inMemWrite = 1; inRegWrite = 0; inMemOrReg = 1;
    inResult = addr; inDataReg2 = data; inMemSize = size;
  endtask

  task automatic test_reset();
    idle(); inStoreReady = 0; reset_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (outRegWrite !== 1'b0) begin failures++;
      $display("FAIL reset_regwrite got=%0b exp=0", outRegWrite); end
    checks++; if (outRegData !== 64'd0 || outDestRegister !== 5'd0) begin failures++;
      $display("FAIL reset_regdata got=%h/%0d exp=0/0", outRegData, outDestRegister); end
    checks++; if (outStoreValid !== 1'b0 || outStbufEmpty !== 1'b1 || outStbufCount !== 3'd0)
      begin failures++; $display("FAIL reset_stbuf got v=%0b e=%0b c=%0d exp 0/1/0",
      outStoreValid, outStbufEmpty, outStbufCount); end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    idle(); inValid = 1; inMemOrReg = 1; inResult = 64'h1234; inDestRegister = 5;
    inRegWrite = 1;
    @(negedge clk);
    checks++; if (outRegData !== 64'h1234 || outDestRegister !== 5'd5 || outRegWrite !== 1'b1)
      begin failures++; $display("FAIL alu_wb got=%h/%0d/%0b exp=1234/5/1",
      outRegData, outDestRegister, outRegWrite); end
    idle();
    @(negedge clk);
    checks++; if (outRegWrite !== 1'b0 || outRegData !== 64'h1234 || outDestRegister !== 5'd5)
      begin failures++; $display("FAIL alu_hold got=%h/%0d/%0b exp=1234/5/0",
      outRegData, outDestRegister, outRegWrite); end
  endtask

  task automatic test_stbuf_full();
    inStoreReady = 0;
    for (int i = 0; i < 4; i++) begin
      do_store(64'h100 + 64'(8 * i), 64'hA0 + 64'(i), 2'(i));
      #1;
      checks++; if (outStall !== 1'b0) begin failures++;
        $display("FAIL fill_nostall[%0d] got=%0b exp=0", i, outStall); end
      @(negedge clk);
    end
    idle();
    checks++; if (outStbufCount !== 3'd4) begin failures++;
      $display("FAIL fill_count got=%0d exp=4", outStbufCount); end
    do_store(64'h999, 64'h999, 2'd3);
    #1;
    checks++; if (outStall !== 1'b1) begin failures++;
      $display("FAIL full_stall got=%0b exp=1", outStall); end
    @(negedge clk);
    idle();
    checks++; if (outStbufCount !== 3'd4 || outStoreAddr !== 64'h100) begin failures++;
      $display("FAIL full_hold got c=%0d a=%h exp 4/100", outStbufCount, outStoreAddr); end
    @(negedge clk);
    checks++; if (outStoreData !== 64'hA0 || outStoreValid !== 1'b1) begin failures++;
      $display("FAIL head_stable got d=%h v=%0b exp a0/1", outStoreData, outStoreValid); end
    inStoreReady = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outStoreValid !== 1'b1 || outStoreAddr !== 64'h100 + 64'(8 * i) ||
          outStoreData !== 64'hA0 + 64'(i) || outStoreSize !== 2'(i)) begin
        failures++;
        $display("FAIL drain[%0d] got v=%0b a=%h d=%h s=%0d", i, outStoreValid, outStoreAddr,
                 outStoreData, outStoreSize);
      end
      @(negedge clk);
    end
    inStoreReady = 0;
    checks++; if (outStbufCount !== 3'd0 || outStbufEmpty !== 1'b1 || outStoreValid !== 1'b0)
      begin failures++; $display("FAIL drain_empty got c=%0d e=%0b v=%0b exp 0/1/0",
      outStbufCount, outStbufEmpty, outStoreValid); end
  endtask

  task automatic test_full_no_bypass();
    inStoreReady = 0;
    for (int i = 0; i < 4; i++) begin
      do_store(64'h300 + 64'(8 * i), 64'hC0 + 64'(i), 2'd2);
      @(negedge clk);
    end
    do_store(64'h400, 64'hDD, 2'd3);
    inStoreReady = 1;
    #1;
    checks++; if (outStall !== 1'b1) begin failures++;
      $display("FAIL bypass_stall got=%0b exp=1", outStall); end
    @(negedge clk);
    idle(); inStoreReady = 0;
    checks++; if (outStbufCount !== 3'd3 || outStoreAddr !== 64'h308) begin failures++;
      $display("FAIL bypass_count got c=%0d a=%h exp 3/308", outStbufCount, outStoreAddr); end
    inStoreReady = 1;
    repeat (3) @(negedge clk);
    inStoreReady = 0;
    checks++; if (outStbufCount !== 3'd0) begin failures++;
      $display("FAIL bypass_drain got=%0d exp=0", outStbufCount); end
  endtask

  task automatic test_load_ext();
    logic [63:0] exp_s8, exp_s16, exp_u32, rd32;
`ifdef WB_LOAD_EXT_EN
    exp_s8 = 64'hFFFF_FFFF_FFFF_FF80; exp_s16 = 64'hFFFF_FFFF_FFFF_8765;
    exp_u32 = 64'h0000_0000_8000_0001;
`else
    exp_s8 = 64'h80; exp_s16 = 64'h0000_0000_1234_8765; exp_u32 = 64'hFFFF_FFFF_8000_0001;
`endif
    rd32 = 64'hFFFF_FFFF_8000_0001;
    idle(); inValid = 1; inMemOrReg = 0; inRegWrite = 1; inDestRegister = 7;
    inReadData = 64'h80; inMemSize = 2'd0; inLoadUnsigned = 0;
    @(negedge clk);
    checks++; if (outRegData !== exp_s8) begin failures++;
      $display("FAIL load_b_signed got=%h exp=%h", outRegData, exp_s8); end
    inLoadUnsigned = 1;
    @(negedge clk);
    checks++; if (outRegData !== 64'h80) begin failures++;
      $display("FAIL load_b_unsigned got=%h exp=80", outRegData); end
    inLoadUnsigned = 0; inMemSize = 2'd1; inReadData = 64'h0000_0000_1234_8765;
    @(negedge clk);
    checks++; if (outRegData !== exp_s16) begin failures++;
      $display("FAIL load_h_signed got=%h exp=%h", outRegData, exp_s16); end
    inLoadUnsigned = 1; inMemSize = 2'd2; inReadData = rd32;
    @(negedge clk);
    checks++; if (outRegData !== exp_u32 || outRegWrite !== 1'b1) begin failures++;
      $display("FAIL load_w_unsigned got=%h/%0b exp=%h/1", outRegData, outRegWrite, exp_u32); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_dest_zero();
    idle(); inValid = 1; inMemOrReg = 1; inResult = 64'h55; inDestRegister = 0; inRegWrite = 1;
    @(negedge clk);
    checks++; if (outRegWrite !== 1'b0 || outRegData !== 64'h55) begin failures++;
      $display("FAIL dest_zero got=%0b/%h exp=0/55", outRegWrite, outRegData); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_drain();
    inStoreReady = 0;
    for (int i = 0; i < 2; i++) begin
      do_store(64'h500 + 64'(8 * i), 64'hE0 + 64'(i), 2'd3);
      @(negedge clk);
    end
    idle();
    checks++; if (outStbufCount !== 3'd2) begin failures++;
      $display("FAIL mid_fill got=%0d exp=2", outStbufCount); end
    inStoreReady = 1;
    #2 reset_n = 0;
    #1;
    checks++; if (outStoreValid !== 1'b0 || outStbufCount !== 3'd0 || outStbufEmpty !== 1'b1)
      begin failures++; $display("FAIL mid_reset got v=%0b c=%0d e=%0b exp 0/0/1",
      outStoreValid, outStbufCount, outStbufEmpty); end
    @(negedge clk);
    reset_n = 1; inStoreReady = 0;
    @(negedge clk);
    checks++; if (outStbufEmpty !== 1'b1 || outRegData !== 64'd0) begin failures++;
      $display("FAIL post_reset got e=%0b d=%h exp 1/0", outStbufEmpty, outRegData); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_stbuf_full();
    test_full_no_bypass();
    test_load_ext();
    test_dest_zero();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
